arm_data_mem: RTL

ARM_DATA_MEM -- requirements
Module: arm_data_mem

---
 rtl/arm_mem_pkg.sv | 29 ++
 rtl/arm_mem_extend.sv | 36 +++
 rtl/arm_data_mem.sv | 118 +++++++++++
 3 files changed

// File: rtl/arm_mem_pkg.sv
// Shared definitions for the ARM data memory: access-size encoding plus the
// alignment check and byte-lane mask helpers used by the read and write ports.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } mem_size_e;

  // Widest supported word is 64 bits, so masks never need more than 8 lanes.
  localparam int MAX_LANES = 8;

  function automatic logic access_ok(input logic [2:0] offset, input logic [1:0] size,
                                     input int nbytes);
    logic [3:0] span;
    span = 4'd1 << size;
    return (int'(span) <= nbytes) && ((offset & 3'(span - 4'd1)) == 3'd0);
  endfunction

  function automatic logic [MAX_LANES-1:0] lane_mask(input logic [2:0] offset,
                                                     input logic [1:0] size);
    logic [MAX_LANES-1:0] base;
    base = 8'((9'd1 << (4'd1 << size)) - 9'd1);
    return base << offset;
  endfunction

endpackage

// File: rtl/arm_mem_extend.sv
// Read-path extraction: selects the addressed bytes out of a stored word and
// zero- or sign-extends them to the full data width.
module arm_mem_extend
  import arm_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int NBYTES = DATA_WIDTH / 8,
  localparam int OW = $clog2(NBYTES)
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [OW-1:0]         offset,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] shifted;
  logic                  top_bit;
  int                    nbits;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    nbits   = 8 << size;
    top_bit = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i == nbits - 1) top_bit = shifted[i];
    end
    top_bit = top_bit & sign_ext;
    data = '0;
    // Full-width accesses never reach the fill branch, so sign_ext is moot there.
    for (int i = 0; i < DATA_WIDTH; i++) begin
      data[i] = (i < nbits) ? shifted[i] : top_bit;
    end
  end

endmodule

// File: rtl/arm_data_mem.sv
// Byte-addressable little-endian data memory with one read and one write port.
// Optional macro ARM_DATA_MEM_FWD_EN forwards same-cycle write bytes into reads.
module arm_data_mem
  import arm_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_WORDS = 256,
  localparam int NBYTES = DATA_WIDTH / 8,
  localparam int AW = $clog2(DEPTH_WORDS * NBYTES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write,
  input  logic [AW-1:0]         write_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [1:0]            wr_size,
  input  logic                  read,
  input  logic [AW-1:0]         read_addr,
  input  logic [1:0]            rd_size,
  input  logic                  rd_signed,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_done,
  output logic                  wr_done,
  output logic                  rd_err,
  output logic                  wr_err
);

  localparam int OW = $clog2(NBYTES);
  localparam int IW = AW - OW;

  logic [OW-1:0]         wr_off, rd_off;
  logic [IW-1:0]         wr_idx, rd_idx;
  logic                  wr_ok, rd_ok, wr_en, rd_en;
  logic [NBYTES-1:0]     wr_lanes;
  logic [DATA_WIDTH-1:0] wr_shift;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [OW-1:0] rd_off_reg;
  logic [1:0]    rd_size_reg;
  logic          rd_signed_reg;
  logic          rd_done_reg, wr_done_reg, rd_err_reg, wr_err_reg;

  assign wr_off   = write_addr[OW-1:0];
  assign wr_idx   = write_addr[AW-1:OW];
  assign rd_off   = read_addr[OW-1:0];
  assign rd_idx   = read_addr[AW-1:OW];
  assign wr_ok    = access_ok(3'(wr_off), wr_size, NBYTES);
  assign rd_ok    = access_ok(3'(rd_off), rd_size, NBYTES);
  assign wr_en    = write & ~rst & wr_ok;
  assign rd_en    = read & ~rst & rd_ok;
  assign wr_lanes = NBYTES'(lane_mask(3'(wr_off), wr_size));
  // Right-justified write data moved up to its byte lanes.
  assign wr_shift = wr_data << {wr_off, 3'b000};

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] rd_byte;
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
        if (wr_en && wr_lanes[gi]) mem[wr_idx] <= wr_shift[gi*8 +: 8];
      end

`ifdef ARM_DATA_MEM_FWD_EN
      assign rd_byte = (wr_en && wr_lanes[gi] && (wr_idx == rd_idx)) ?
                       wr_shift[gi*8 +: 8] : mem[rd_idx];
`else
      assign rd_byte = mem[rd_idx];
`endif

      always_ff @(posedge clk) begin
        if (rst)        rd_q <= '0;
        else if (rd_en) rd_q <= rd_byte;
      end

      assign rd_word[gi*8 +: 8] = rd_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_off_reg    <= '0;
      rd_size_reg   <= '0;
      rd_signed_reg <= 1'b0;
      rd_done_reg   <= 1'b0;
      wr_done_reg   <= 1'b0;
      rd_err_reg    <= 1'b0;
      wr_err_reg    <= 1'b0;
    end else begin
      rd_done_reg <= read;
      wr_done_reg <= write;
      rd_err_reg  <= read & ~rd_ok;
      wr_err_reg  <= write & ~wr_ok;
      // Failed reads keep the previous shaping so rd_data holds its value.
      if (rd_en) begin
        rd_off_reg    <= rd_off;
        rd_size_reg   <= rd_size;
        rd_signed_reg <= rd_signed;
      end
    end
  end

  arm_mem_extend #(.DATA_WIDTH(DATA_WIDTH)) u_extend (
    .word     (rd_word),
    .offset   (rd_off_reg),
    .size     (rd_size_reg),
    .sign_ext (rd_signed_reg),
    .data     (rd_data)
  );

  assign rd_done = rd_done_reg;
  assign wr_done = wr_done_reg;
  assign rd_err  = rd_err_reg;
  assign wr_err  = wr_err_reg;

endmodule
